// File: rtl/idu.sv
// Instruction decode unit: a small circular instruction buffer feeding an
// RV32I-subset decoder, with RUN / WFI / HALT core-state control.
module idu #(
  parameter int BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_vld,
  input  logic        ifu_idu_vld,
  input  logic [31:0] ifu_idu_ins,
  input  logic [31:0] ifu_idu_pc,
  input  logic        alu_ifu_br_vld,
  input  logic        alu_idu_rdy,
  output logic        idu_ifu_rdy,
  output logic        idu_ifu_wfi,
  output logic        idu_alu_vld,
  output logic [31:0] idu_alu_pc,
  output logic [3:0]  idu_alu_op,
  output logic [3:0]  idu_alu_funct,
  output logic [4:0]  idu_alu_rd,
  output logic [4:0]  idu_alu_rs1,
  output logic [4:0]  idu_alu_rs2,
  output logic [31:0] idu_alu_imm,
  output logic        idu_halt
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {RUN, WFI, HALT} state_t;

  state_t          state, state_nxt;
  logic [31:0]     ins_mem [BUF_DEPTH];
  logic [31:0]     pc_mem  [BUF_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic [31:0]     head_ins;
  logic            head_legal;
  logic            head_is_wfi;
  logic            non_empty;
  logic            full;
  logic            push;
  logic            pop;

  assign head_ins    = ins_mem[rd_ptr];
  assign idu_alu_pc  = pc_mem[rd_ptr];
  assign non_empty   = (count != '0);
  assign full        = (count == CW'(BUF_DEPTH));

  assign idu_ifu_rdy = (state == RUN) && !full;
  assign idu_alu_vld = (state == RUN) && non_empty && head_legal;
  assign idu_ifu_wfi = (state == WFI) || (state == HALT);
  assign idu_halt    = (state == HALT);

  assign push        = ifu_idu_vld && idu_ifu_rdy;
  assign pop         = idu_alu_vld && alu_idu_rdy;

  assign idu_alu_funct = {head_ins[30], head_ins[14:12]};
  assign idu_alu_rd    = head_ins[11:7];
  assign idu_alu_rs1   = head_ins[19:15];
  assign idu_alu_rs2   = head_ins[24:20];
  assign head_is_wfi   = (head_ins == 32'h1050_0073);

  // Decode the head entry: op class, immediate and legality.
  always_comb begin
    idu_alu_op  = '0;
    idu_alu_imm = '0;
    head_legal  = 1'b1;
    if (head_is_wfi) begin
      idu_alu_op = 4'd9;
    end else begin
      case (head_ins[6:0])
        7'b0110011: idu_alu_op = 4'd0;
        7'b0010011: begin
          idu_alu_op  = 4'd1;
          idu_alu_imm = {{20{head_ins[31]}}, head_ins[31:20]};
        end
        7'b0000011: begin
          idu_alu_op  = 4'd2;
          idu_alu_imm = {{20{head_ins[31]}}, head_ins[31:20]};
        end
        7'b0100011: begin
          idu_alu_op  = 4'd3;
          idu_alu_imm = {{20{head_ins[31]}}, head_ins[31:25], head_ins[11:7]};
        end
        7'b1100011: begin
          idu_alu_op  = 4'd4;
          idu_alu_imm = {{19{head_ins[31]}}, head_ins[31], head_ins[7],
                         head_ins[30:25], head_ins[11:8], 1'b0};
        end
        7'b1101111: begin
          idu_alu_op  = 4'd5;
          idu_alu_imm = {{11{head_ins[31]}}, head_ins[31], head_ins[19:12],
                         head_ins[20], head_ins[30:21], 1'b0};
        end
        7'b1100111: begin
          idu_alu_op  = 4'd6;
          idu_alu_imm = {{20{head_ins[31]}}, head_ins[31:20]};
        end
        7'b0110111: begin
          idu_alu_op  = 4'd7;
          idu_alu_imm = {head_ins[31:12], 12'b0};
        end
        7'b0010111: begin
          idu_alu_op  = 4'd8;
          idu_alu_imm = {head_ins[31:12], 12'b0};
        end
        default: head_legal = 1'b0;
      endcase
    end
  end

  // Next state and buffer pointer/count; start and branch flush take priority.
  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (start_vld) begin
      state_nxt  = RUN;
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else if (alu_ifu_br_vld) begin
      if (state == WFI) state_nxt = RUN;
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else if (state == RUN) begin
      if (pop && head_is_wfi) begin
        // Retiring WFI discards any younger buffered or arriving fetch.
        state_nxt  = WFI;
        wr_ptr_nxt = '0;
        rd_ptr_nxt = '0;
        count_nxt  = '0;
      end else begin
        if (non_empty && !head_legal) state_nxt = HALT;
        if (push) wr_ptr_nxt = wr_ptr + PW'(1);
        if (pop)  rd_ptr_nxt = rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count_nxt = count + CW'(1);
          2'b01:   count_nxt = count - CW'(1);
          default: count_nxt = count;
        endcase
      end
    end
  end

  // State, pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state  <= state_nxt;
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
    end
  end

  // Buffer payload; no reset needed since count gates its visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      ins_mem[wr_ptr] <= ifu_idu_ins;
      pc_mem[wr_ptr]  <= ifu_idu_pc;
    end
  end

endmodule

// File: tb/tb_idu.sv
// Self-checking bench for idu: directed scenarios followed by random traffic,
// all compared against a queue-based behavioural model.
module tb_idu;
  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_vld, ifu_idu_vld, alu_ifu_br_vld, alu_idu_rdy;
  logic [31:0] ifu_idu_ins, ifu_idu_pc;
  logic        idu_ifu_rdy, idu_ifu_wfi, idu_alu_vld, idu_halt;
  logic [31:0] idu_alu_pc, idu_alu_imm;
  logic [3:0]  idu_alu_op, idu_alu_funct;
  logic [4:0]  idu_alu_rd, idu_alu_rs1, idu_alu_rs2;

  idu #(.BUF_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .start_vld(start_vld),
    .ifu_idu_vld(ifu_idu_vld), .ifu_idu_ins(ifu_idu_ins), .ifu_idu_pc(ifu_idu_pc),
    .alu_ifu_br_vld(alu_ifu_br_vld), .alu_idu_rdy(alu_idu_rdy),
    .idu_ifu_rdy(idu_ifu_rdy), .idu_ifu_wfi(idu_ifu_wfi), .idu_alu_vld(idu_alu_vld),
    .idu_alu_pc(idu_alu_pc), .idu_alu_op(idu_alu_op), .idu_alu_funct(idu_alu_funct),
    .idu_alu_rd(idu_alu_rd), .idu_alu_rs1(idu_alu_rs1), .idu_alu_rs2(idu_alu_rs2),
    .idu_alu_imm(idu_alu_imm), .idu_halt(idu_halt)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned npass = 0;
  logic [63:0] q[$];     // {ins, pc}, oldest first
  int          mode;     // 0 running, 1 waiting for interrupt, 2 halted

  function automatic int ref_op(input logic [31:0] i);
    if (i == 32'h1050_0073) return 9;
    case (i[6:0])
      7'b0110011: return 0;
      7'b0010011: return 1;
      7'b0000011: return 2;
      7'b0100011: return 3;
      7'b1100011: return 4;
      7'b1101111: return 5;
      7'b1100111: return 6;
      7'b0110111: return 7;
      7'b0010111: return 8;
      default:    return -1;
    endcase
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    logic [31:0] s;
    s = i[31] ? 32'hFFFF_FFFF : 32'h0;
    case (ref_op(i))
      1, 2, 6: return (s << 12) | (i >> 20);
      3:       return (s << 12) | ((i >> 25) << 5) | ((i >> 7) & 32'h1F);
      4:       return (s << 12) | (((i >> 7) & 32'h1) << 11) |
                      (((i >> 25) & 32'h3F) << 5) | (((i >> 8) & 32'hF) << 1);
      5:       return (s << 20) | (i & 32'h000F_F000) | (((i >> 20) & 32'h1) << 11) |
                      (((i >> 21) & 32'h3FF) << 1);
      7, 8:    return i & 32'hFFFF_F000;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit exp_rdy();
    return (mode == 0) && (q.size() < D);
  endfunction

  function automatic bit exp_vld();
    return (mode == 0) && (q.size() > 0) && (ref_op(q[0][63:32]) >= 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all();
    logic [31:0] hi;
    chk("rdy",  32'(idu_ifu_rdy), 32'(exp_rdy()));
    chk("vld",  32'(idu_alu_vld), 32'(exp_vld()));
    chk("wfi",  32'(idu_ifu_wfi), 32'(mode != 0));
    chk("halt", 32'(idu_halt),    32'(mode == 2));
    if (exp_vld()) begin
      hi = q[0][63:32];
      chk("pc",    idu_alu_pc,           q[0][31:0]);
      chk("op",    32'(idu_alu_op),      32'(ref_op(hi)));
      chk("funct", 32'(idu_alu_funct),   ((hi >> 27) & 32'h8) | ((hi >> 12) & 32'h7));
      chk("rd",    32'(idu_alu_rd),      (hi >> 7) & 32'h1F);
      chk("rs1",   32'(idu_alu_rs1),     (hi >> 15) & 32'h1F);
      chk("rs2",   32'(idu_alu_rs2),     (hi >> 20) & 32'h1F);
      chk("imm",   idu_alu_imm,          ref_imm(hi));
    end
  endtask

  // Apply one clock edge to the model using the inputs present at that edge.
  task automatic model_edge();
    bit push, pop;
    push = ifu_idu_vld && exp_rdy();
    pop  = exp_vld() && alu_idu_rdy;
    if (start_vld) begin
      q.delete(); mode = 0;
    end else if (alu_ifu_br_vld) begin
      q.delete(); if (mode == 1) mode = 0;
    end else if (mode == 0) begin
      if (pop && ref_op(q[0][63:32]) == 9) begin
        q.delete(); mode = 1;
      end else begin
        if (q.size() > 0 && ref_op(q[0][63:32]) < 0) mode = 2;
        if (pop) void'(q.pop_front());
        if (push) q.push_back({ifu_idu_ins, ifu_idu_pc});
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drv(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic ardy, input logic br, input logic st);
    ifu_idu_vld = v; ifu_idu_ins = ins; ifu_idu_pc = pc;
    alu_idu_rdy = ardy; alu_ifu_br_vld = br; start_vld = st;
  endtask

  function automatic logic [31:0] rand_ins();
    logic [6:0]  opc [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                             7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    logic [31:0] r;
    int unsigned k;
    r = $urandom;
    k = $urandom_range(0, 39);
    if (k == 0) return 32'hFFFF_FFFF;
    if (k < 3)  return 32'h1050_0073;
    r[6:0] = opc[$urandom_range(0, 8)];
    return r;
  endfunction

  initial begin
    mode = 0;
    rst_n = 1'b0;
    drv(0, '0, '0, 0, 0, 0);
    #3;
    check_all();
    chk("reset_rdy", 32'(idu_ifu_rdy), 32'd1);
    #9 rst_n = 1'b1;

    // addi x1,x0,5 flows through in one cycle
    drv(1, 32'h0050_0093, 32'h0, 1, 0, 0);
    step();
    drv(0, '0, '0, 1, 0, 0);
    chk("addi_op",  32'(idu_alu_op), 32'd1);
    chk("addi_imm", idu_alu_imm, 32'd5);
    chk("addi_rd",  32'(idu_alu_rd), 32'd1);
    step();

    // fill with execute stalled, then drain in order
    drv(1, 32'h0010_0113, 32'h100, 0, 0, 0); step();
    drv(1, 32'h0020_0193, 32'h104, 0, 0, 0); step();
    chk("full_rdy", 32'(idu_ifu_rdy), 32'd0);
    drv(0, '0, '0, 1, 0, 0); step();
    chk("drain_pc", idu_alu_pc, 32'h104);
    step();

    // beq with negative offset
    drv(1, 32'hFE00_0EE3, 32'h200, 0, 0, 0); step();
    chk("beq_imm", idu_alu_imm, 32'hFFFF_FFFC);
    drv(0, '0, '0, 1, 0, 0); step();

    // WFI followed by younger addi; wake with start
    drv(1, 32'h1050_0073, 32'h300, 0, 0, 0); step();
    drv(1, 32'h0050_0093, 32'h304, 0, 0, 0); step();
    drv(0, '0, '0, 1, 0, 0); step();
    chk("wfi_set", 32'(idu_ifu_wfi), 32'd1);
    step();
    drv(0, '0, '0, 1, 0, 1); step();
    drv(0, '0, '0, 1, 0, 0);
    chk("wake_rdy", 32'(idu_ifu_rdy), 32'd1);

    // illegal instruction halts until start
    drv(1, 32'hFFFF_FFFF, 32'h400, 1, 0, 0); step();
    drv(0, '0, '0, 1, 0, 0); step();
    chk("halted", 32'(idu_halt), 32'd1);
    drv(0, '0, '0, 1, 0, 1); step();
    drv(0, '0, '0, 1, 0, 0); step();

    // branch flush with a same-cycle push
    drv(1, 32'h0010_0113, 32'h500, 0, 0, 0); step();
    drv(1, 32'h0020_0193, 32'h504, 0, 0, 0); step();
    drv(1, 32'h0030_0213, 32'h508, 0, 1, 0); step();
    drv(0, '0, '0, 0, 0, 0);
    chk("flush_vld", 32'(idu_alu_vld), 32'd0);

    // asynchronous reset mid-operation
    drv(1, 32'h0010_0113, 32'h600, 0, 0, 0); step();
    drv(0, '0, '0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    q.delete(); mode = 0;
    check_all();
    #2 rst_n = 1'b1;

    // random traffic
    for (int n = 0; n < 500; n++) begin
      drv($urandom_range(0, 9) < 7, rand_ins(), $urandom,
          $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0,
          $urandom_range(0, 29) == 0);
      step();
    end

    $display("%0d/%0d checks passed", npass, total);
    $finish;
  end
endmodule
